// File: rtl/panda_risc_v_ifu_pkg.sv
// Shared IFU types and constants for the program-counter generator.
package panda_risc_v_ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } pc_gen_state_t;

  localparam int unsigned PC_INC           = 4;
  localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/panda_risc_v_pc_gen.sv
// IFU PC generator: requests a base PC, then streams burst_len word-aligned fetch addresses.
// Optional macro PC_GEN_MISALIGN_CHK_EN adds the ERR state and the m_misalign output.
module panda_risc_v_pc_gen
  import panda_risc_v_ifu_pkg::*;
#(
  parameter int  pc_width         = 32,
  parameter int  burst_len        = 4,
  parameter real simulation_delay = 1.0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                flush_i,
  output logic                req,
  input  logic                grant,
  input  logic [pc_width-1:0] payload,
  output logic [pc_width-1:0] m_addr,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy
`ifdef PC_GEN_MISALIGN_CHK_EN
  ,
  output logic                m_misalign
`endif
);

  localparam int CNT_W = (burst_len > 1) ? $clog2(burst_len) : 1;
  // Counter value of the beat before the last one; unused when burst_len == 1.
  localparam logic [CNT_W-1:0] CNT_PEN = CNT_W'((burst_len >= 2) ? burst_len - 2 : 0);

  if (burst_len < 1 || simulation_delay < 0.0) begin : g_bad_param
    $error("panda_risc_v_pc_gen: burst_len must be >= 1 and simulation_delay >= 0");
  end

  pc_gen_state_t      state;
  logic [CNT_W-1:0]   cnt;
  logic [pc_width-1:0] aligned_payload;

  assign aligned_payload = payload & ~{{(pc_width-2){1'b0}}, INSTR_ALIGN_MASK};

  // m_addr is the PC register itself, so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req     <= 1'b0;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
`ifdef PC_GEN_MISALIGN_CHK_EN
      m_misalign <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (start_i) begin
        state <= REQ;
        req   <= 1'b1;
        busy  <= 1'b1;
      end
    end else if (flush_i) begin
      state   <= REQ;
      req     <= 1'b1;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
`ifdef PC_GEN_MISALIGN_CHK_EN
      m_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        REQ: begin
          if (grant) begin
            req     <= 1'b0;
            m_valid <= 1'b1;
            cnt     <= '0;
`ifdef PC_GEN_MISALIGN_CHK_EN
            if (|(payload[1:0] & INSTR_ALIGN_MASK)) begin
              state      <= ERR;
              m_addr     <= payload;
              m_last     <= 1'b1;
              m_misalign <= 1'b1;
            end else begin
              state  <= RUN;
              m_addr <= aligned_payload;
              m_last <= (burst_len == 1);
            end
`else
            state  <= RUN;
            m_addr <= aligned_payload;
            m_last <= (burst_len == 1);
`endif
          end
        end
        RUN: begin
          if (m_valid && m_ready) begin
            m_addr <= m_addr + pc_width'(PC_INC);
            cnt    <= cnt + 1'b1;
            if (m_last) begin
              state   <= REQ;
              req     <= 1'b1;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end else begin
              m_last <= (cnt == CNT_PEN);
            end
          end
        end
`ifdef PC_GEN_MISALIGN_CHK_EN
        ERR: begin
          if (m_valid && m_ready) begin
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_misalign <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_panda_risc_v_pc_gen.sv
// Self-checking bench for panda_risc_v_pc_gen: directed table, corner sequences, random vs queue model.
module tb_panda_risc_v_pc_gen;

  localparam int W  = 32;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         grant = 1'b0;
  logic         m_ready = 1'b0;
  logic [W-1:0] payload = '0;
  logic         req, m_valid, m_last, busy;
  logic [W-1:0] m_addr;
`ifdef PC_GEN_MISALIGN_CHK_EN
  logic         m_misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  panda_risc_v_pc_gen #(
    .pc_width(W),
    .burst_len(BL),
    .simulation_delay(1.0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .flush_i(flush_i),
    .req(req),
    .grant(grant),
    .payload(payload),
    .m_addr(m_addr),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .busy(busy)
`ifdef PC_GEN_MISALIGN_CHK_EN
    ,
    .m_misalign(m_misalign)
`endif
  );

  typedef struct {
    logic [W-1:0]       payload;
    int                 delay;
    logic [3:0]         pat;
    logic [3:0][W-1:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [W-1:0] p, input int d, input logic [3:0] pat,
                              input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [W-1:0] e2, input logic [W-1:0] e3);
    vec_t v;
    v.payload = p;
    v.delay   = d;
    v.pat     = pat;
    v.exp[0]  = e0;
    v.exp[1]  = e1;
    v.exp[2]  = e2;
    v.exp[3]  = e3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with req expected high; returns at the negedge after the grant edge.
  task automatic give_grant(input logic [W-1:0] p, input int d);
    for (int i = 0; i < d; i++) begin
      chk("req_wait", req, 1);
      chk("valid_wait", m_valid, 0);
      @(negedge clk);
    end
    chk("req_at_grant", req, 1);
    grant   = 1'b1;
    payload = p;
    @(negedge clk);
    grant   = 1'b0;
    payload = $urandom;
    chk("req_drop", req, 0);
  endtask

  task automatic stream(input logic [W-1:0] base, input int from, input int n);
    m_ready = 1'b1;
    for (int i = from; i < from + n; i++) begin
      chk("s_valid", m_valid, 1);
      chk("s_addr", m_addr, base + W'(4 * i));
      chk("s_last", m_last, W'(i == BL - 1));
      @(negedge clk);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, c;
    bit started;
    logic exp_req;
    logic [W-1:0] q[$];

    vecs.push_back(mk(32'd2016, 2, 4'b1111, 32'd2016, 32'd2020, 32'd2024, 32'd2028));
    vecs.push_back(mk(32'd2020, 0, 4'b1010, 32'd2020, 32'd2024, 32'd2028, 32'd2032));
    vecs.push_back(mk(32'd2040, 1, 4'b1010, 32'd2040, 32'd2044, 32'd2048, 32'd2052));
    vecs.push_back(mk(32'd2076, 3, 4'b1100, 32'd2076, 32'd2080, 32'd2084, 32'd2088));
    vecs.push_back(mk(32'hFFFF_FFF8, 1, 4'b1111, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4));
`ifndef PC_GEN_MISALIGN_CHK_EN
    vecs.push_back(mk(32'd2018, 0, 4'b1111, 32'd2016, 32'd2020, 32'd2024, 32'd2028));
`endif

    // Reset state
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // flush_i in IDLE is ignored
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("idle_flush_req", req, 0);
    chk("idle_flush_busy", busy, 0);
    @(negedge clk);
    chk("idle_req", req, 0);

    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_req", req, 1);
    chk("start_busy", busy, 1);
    chk("start_valid", m_valid, 0);

    // Table of full bursts with grant latency and backpressure
    foreach (vecs[k]) begin
      give_grant(vecs[k].payload, vecs[k].delay);
      beats = 0;
      c = 0;
      while (beats < BL && c < 40) begin
        chk("t_valid", m_valid, 1);
        chk("t_addr", m_addr, vecs[k].exp[beats]);
        chk("t_last", m_last, W'(beats == BL - 1));
        m_ready = vecs[k].pat[3 - (c % 4)];
        @(negedge clk);
        if (m_ready) beats++;
        c++;
      end
      m_ready = 1'b0;
      chk("t_beats", W'(beats), W'(BL));
      chk("t_req_after", req, 1);
      chk("t_valid_after", m_valid, 0);
    end

    // Flush after two accepted beats, then restart from a new base
    give_grant(32'd2040, 1);
    stream(32'd2040, 0, 2);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_valid", m_valid, 0);
    chk("flush_req", req, 1);
    chk("flush_last", m_last, 0);
    give_grant(32'd2060, 0);
    stream(32'd2060, 0, 4);
    chk("restart_req", req, 1);

    // Flush together with grant: payload dropped, req stays high
    grant   = 1'b1;
    payload = 32'd2032;
    flush_i = 1'b1;
    @(negedge clk);
    grant   = 1'b0;
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fg_valid", m_valid, 0);
      chk("fg_req", req, 1);
      @(negedge clk);
    end

    // start_i held through RUN has no effect
    start_i = 1'b1;
    give_grant(32'd2100, 0);
    stream(32'd2100, 0, 4);
    start_i = 1'b0;
    chk("start_run_req", req, 1);
    chk("start_run_valid", m_valid, 0);

    // Flush coinciding with a handshake
    give_grant(32'd2200, 0);
    chk("fh_addr", m_addr, 32'd2200);
    m_ready = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    flush_i = 1'b0;
    chk("fh_valid", m_valid, 0);
    chk("fh_req", req, 1);

`ifdef PC_GEN_MISALIGN_CHK_EN
    give_grant(32'd2018, 0);
    chk("mis_addr", m_addr, 32'd2018);
    chk("mis_flag", m_misalign, 1);
    chk("mis_last", m_last, 1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mis_idle_valid", m_valid, 0);
      chk("mis_idle_req", req, 0);
      @(negedge clk);
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("mis_flush_req", req, 1);
`endif

    // Asynchronous reset in the middle of RUN
    give_grant(32'd2300, 2);
    stream(32'd2300, 0, 1);
    chk("ar_valid_before", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", req, 0);
    chk("ar_valid", m_valid, 0);
    chk("ar_addr", m_addr, 0);
    chk("ar_last", m_last, 0);
    chk("ar_busy", busy, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_idle_busy", busy, 0);
    chk("ar_idle_req", req, 0);

    // Random traffic against a queue-of-pending-addresses model
    started = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      exp_req = started && (q.size() == 0);
      chk("r_valid", m_valid, W'(q.size() != 0));
      if (q.size() != 0) begin
        chk("r_addr", m_addr, q[0]);
        chk("r_last", m_last, W'(q.size() == 1));
      end
      chk("r_req", req, W'(exp_req));
      chk("r_busy", busy, W'(started));

      start_i = ($urandom_range(19) == 0);
      flush_i = started && ($urandom_range(24) == 0);
      grant   = exp_req && ($urandom_range(2) == 0);
`ifdef PC_GEN_MISALIGN_CHK_EN
      payload = $urandom & ~32'h3;
`else
      payload = $urandom;
`endif
      m_ready = ($urandom_range(3) != 0);

      if (!started) begin
        if (start_i) started = 1'b1;
      end else if (flush_i) begin
        q.delete();
      end else if (grant) begin
        for (int i = 0; i < BL; i++) q.push_back((payload & ~32'h3) + W'(4 * i));
      end else if (q.size() != 0 && m_ready) begin
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    flush_i = 1'b0;
    grant   = 1'b0;
    m_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
